// File: rtl/pe_rotator_seq.sv
// Multi-cycle lane-wise variable rotate (ROL/ROR): one power-of-two stage per clock, all lanes in parallel.
// Bit 0 is the MSB everywhere; lanes are 8/16/32/64 bits wide as selected by ww.
module pe_rotator_seq #(
   parameter int DW         = 64,
   parameter bit EARLY_DONE = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic          in_op_i,
   input  logic [0:1]    in_ww_i,
   input  logic [0:DW-1] in_ra_i,
   input  logic [0:DW-1] in_rb_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [0:DW-1] out_data_o,
   output logic          busy_o
);
   localparam int AW = $clog2(DW);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] BUSY = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   logic [1:0]    state_q, state_d;
   logic [0:DW-1] data_q, data_d;
   logic [0:DW-1] amt_q, amt_d;
   logic [0:DW-1] out_data_q, out_data_d;
   logic [1:0]    ww_q, ww_d;
   logic          op_q, op_d;
   logic [2:0]    cnt_q, cnt_d;

   logic [0:DW-1] stage_res;
   logic [0:DW-1] cap_mask;
   logic [0:DW-1] cap_amt;
   logic [2:0]    last_cnt;

   // A bit of rb is an amount bit when it sits in the low (3+ww) bits of its lane.
   function automatic logic mask_bit(input logic [1:0] ww, input int j);
      int lw;
      lw = 8 << ww;
      return (j % lw) >= (lw - 3 - int'(ww));
   endfunction

   // Result bit j after stage cnt: taken from its lane neighbour 2^cnt away if the lane's
   // amount bit of that weight is set, otherwise unchanged.
   function automatic logic rot_bit(input logic [0:DW-1] d, input logic [0:DW-1] a,
                                    input logic [1:0] ww, input logic [2:0] cnt,
                                    input logic op, input int j);
      int lw, base, off, sh, src;
      lw   = 8 << ww;
      off  = j % lw;
      base = j - off;
      sh   = 1 << cnt;
      src  = op ? base + ((off - sh + lw) % lw) : base + ((off + sh) % lw);
      if (a[AW'(base + lw - 1 - int'(cnt))])
         return d[AW'(src)];
      return d[AW'(j)];
   endfunction

   for (genvar gi = 0; gi < DW; gi++) begin : g_bit
      assign stage_res[gi] = rot_bit(data_q, amt_q, ww_q, cnt_q, op_q, gi);
      assign cap_mask[gi]  = mask_bit(in_ww_i, gi);
   end

   assign cap_amt  = in_rb_i & cap_mask;
   assign last_cnt = 3'd2 + {1'b0, ww_q};

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      amt_d      = amt_q;
      out_data_d = out_data_q;
      ww_d       = ww_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               data_d  = in_ra_i;
               amt_d   = cap_amt;
               ww_d    = in_ww_i;
               op_d    = in_op_i;
               cnt_d   = 3'd0;
               state_d = BUSY;
               if (EARLY_DONE && (cap_amt == '0)) begin
                  out_data_d = in_ra_i;
                  state_d    = DONE;
               end
            end
         end
         BUSY: begin
            data_d = stage_res;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == last_cnt) begin
               out_data_d = stage_res;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         data_q     <= '0;
         amt_q      <= '0;
         out_data_q <= '0;
         ww_q       <= 2'b00;
         op_q       <= 1'b0;
         cnt_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         amt_q      <= amt_d;
         out_data_q <= out_data_d;
         ww_q       <= ww_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q == BUSY) || (state_q == DONE);
   assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_pe_rotator_seq.sv
// Directed bench for pe_rotator_seq: hand-computed rotate results, latencies, backpressure and reset.
module tb_pe_rotator_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_op = 1'b0;
   logic [0:1]  in_ww = 2'b00;
   logic [0:63] in_ra = '0;
   logic [0:63] in_rb = '0;
   logic        out_ready = 1'b1;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [0:63] out_data;

   int checks = 0;
   int failures = 0;

   pe_rotator_seq #(.DW(64), .EARLY_DONE(1'b1)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_op_i    (in_op),
      .in_ww_i    (in_ww),
      .in_ra_i    (in_ra),
      .in_rb_i    (in_rb),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Latency is counted in clock edges after the accept edge until out_valid is seen.
   task automatic run_op(input string tag, input logic [1:0] ww, input logic op,
                         input logic [63:0] ra, input logic [63:0] rb,
                         input logic [63:0] exp, input int exp_lat, input bit handoff);
      int lat;
      @(negedge clk);
      in_ww = ww; in_op = op; in_ra = ra; in_rb = rb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = ~op; in_ra = ~ra; in_rb = ~rb;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " lat"}, 64'(lat), 64'(exp_lat));
      check({tag, " data"}, out_data, exp);
      $display("op %s ww=%0d op=%0d ra=%h rb=%h -> %h lat=%0d", tag, ww, op, ra, rb, out_data, lat);
      if (handoff) begin
         @(posedge clk); #1;
         check({tag, " handoff"}, 64'(out_valid), 64'(0));
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", 64'(out_valid), 64'(0));
      check("rst out_data", out_data, 64'h0);
      check("rst busy", 64'(busy), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst in_ready", 64'(in_ready), 64'(1));

      run_op("byte_rol1", 2'b00, 1'b0, 64'h8100_0000_0000_0001, 64'h0101_0101_0101_0101,
             64'h0300_0000_0000_0002, 3, 1'b1);
      run_op("word_ror", 2'b10, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0001_0000_001F,
             64'h8000_0000_0000_0001, 5, 1'b1);
      // Upper (ignored) bits of each half carry junk; amounts are 4, 8, 12, 0.
      run_op("half_rol", 2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFFF4_0008_ABCC_5550,
             64'h2341_7856_C9AB_DEF0, 4, 1'b1);
      run_op("byte_ror7", 2'b00, 1'b1, 64'h0102_0408_1020_4080, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h0204_0810_2040_8001, 3, 1'b1);
      run_op("dword_rol4", 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0004,
             64'h1234_5678_9ABC_DEF0, 6, 1'b1);
      run_op("dword_ror60", 2'b11, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_003C,
             64'h1234_5678_9ABC_DEF0, 6, 1'b1);
      // Zero-skip: valid straight after the accept edge.
      run_op("zskip", 2'b01, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,
             64'hDEAD_BEEF_CAFE_F00D, 0, 1'b1);
      run_op("zskip_junk", 2'b01, 1'b1, 64'h0011_2233_4455_6677, 64'hFFF0_FFF0_FFF0_FFF0,
             64'h0011_2233_4455_6677, 0, 1'b1);

      out_ready = 1'b0;
      run_op("bp", 2'b00, 1'b0, 64'h8100_0000_0000_0001, 64'h0101_0101_0101_0101,
             64'h0300_0000_0000_0002, 3, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_ww = 2'b01; in_ra = 64'hFFFF_0000_FFFF_0000; in_rb = '0;
         @(posedge clk); #1;
         check("bp out_valid", 64'(out_valid), 64'(1));
         check("bp in_ready", 64'(in_ready), 64'(0));
         check("bp out_data", out_data, 64'h0300_0000_0000_0002);
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release out_valid", 64'(out_valid), 64'(0));
      check("bp release in_ready", 64'(in_ready), 64'(1));
      check("bp release busy", 64'(busy), 64'(0));
      check("bp release out_data", out_data, 64'h0300_0000_0000_0002);
      @(posedge clk); #1;
      check("bp single handoff", 64'(out_valid), 64'(0));
      $display("op bp held 10 cycles then released");

      @(negedge clk);
      in_ww = 2'b11; in_op = 1'b0; in_ra = 64'h0123_4567_89AB_CDEF; in_rb = 64'h4; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midop busy", 64'(busy), 64'(1));
      check("midop in_ready", 64'(in_ready), 64'(0));
      rst_n = 1'b0;
      #1;
      check("midop rst out_valid", 64'(out_valid), 64'(0));
      check("midop rst out_data", out_data, 64'h0);
      check("midop rst busy", 64'(busy), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("midop post in_ready", 64'(in_ready), 64'(1));
      $display("op reset during BUSY stage 2");
      run_op("post_rst_dword", 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0004,
             64'h1234_5678_9ABC_DEF0, 6, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
